// File: rtl/spi_host_pkg.sv
// spi_host_pkg: default frame geometry and FSM states shared by spi_host and its shifter.
package spi_host_pkg;

    localparam int DEF_WIDTH = 96;
    localparam int DEF_LEN_W = 7;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

endpackage

// File: rtl/spi_host_shifter.sv
// spi_host_shifter: tx/rx shift registers and bit counter; SPI_HOST_LOOPBACK_EN samples o_mosi instead of miso.
module spi_host_shifter
    import spi_host_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             sample,
    input  logic             advance,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             miso,
    output logic             mosi,
    output logic             last,
    output logic [WIDTH-1:0] rx_data
);

    logic [WIDTH-1:0] tx_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] n_q;
    logic [LEN_W-1:0] n_eff;
    logic             rx_bit;

    assign n_eff = (len == '0 || len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign last  = cnt_q == n_q - LEN_W'(1);

`ifdef SPI_HOST_LOOPBACK_EN
    assign rx_bit = mosi;
`else
    assign rx_bit = miso;
`endif

    // mosi is registered so bit k is on the wire for the whole k-th select cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi    <= 1'b0;
            tx_q    <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            rx_data <= '0;
        end else begin
            mosi <= load ? tx_data[0] : advance ? tx_q[0] : 1'b0;
            if (load) begin
                tx_q    <= tx_data >> 1;
                n_q     <= n_eff;
                cnt_q   <= '0;
                rx_data <= '0;
            end else if (sample) begin
                rx_data[cnt_q] <= rx_bit;
                if (advance) begin
                    tx_q  <= tx_q >> 1;
                    cnt_q <= cnt_q + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_host.sv
// spi_host: single-frame SPI host (IDLE/SHIFT/DONE) driving a shift-register slave.
// Build option SPI_HOST_LOOPBACK_EN captures the transmitted bits instead of i_miso.
module spi_host
    import spi_host_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [LEN_W-1:0] i_len,
    input  logic [WIDTH-1:0] i_tx_data,
    output logic             o_ss,
    output logic             o_mosi,
    input  logic             i_miso,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_busy,
    output logic             o_done
);

    state_t state_q;
    state_t state_d;
    logic   load;
    logic   sample;
    logic   advance;
    logic   last;

    assign load    = state_q == IDLE && i_start && !i_abort;
    assign sample  = state_q == SHIFT;
    assign advance = sample && !i_abort && !last;

    // abort wins over completion of the last bit
    always_comb begin
        state_d = load ? SHIFT : sample ? (i_abort ? IDLE : last ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            o_ss    <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_ss    <= state_d == SHIFT;
            o_busy  <= state_d != IDLE;
            o_done  <= state_d == DONE;
        end
    end

    spi_host_shifter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .sample  (sample),
        .advance (advance),
        .len     (i_len),
        .tx_data (i_tx_data),
        .miso    (i_miso),
        .mosi    (o_mosi),
        .last    (last),
        .rx_data (o_rx_data)
    );

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed frames against a shift-register slave model with hand-computed results.
module tb_spi_host;

    localparam logic [95:0] A5 = 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [95:0] TX96 = 96'h01234567_89ABCDEF_00FF00FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [6:0]  i_len = '0;
    logic [95:0] i_tx_data = '0;
    logic        i_miso;
    logic        o_ss, o_mosi, o_busy, o_done;
    logic [95:0] o_rx_data;

    logic [95:0] sreg = '0;
    logic [95:0] slave_load = '0;
    logic [95:0] slave_mask = '1;
    int          slave_len = 96;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    spi_host dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_len     (i_len),
        .i_tx_data (i_tx_data),
        .o_ss      (o_ss),
        .o_mosi    (o_mosi),
        .i_miso    (i_miso),
        .o_rx_data (o_rx_data),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    // slave: reloads while deselected, shifts LSB out and mosi in at the top while selected
    always @(posedge clk) begin
        if (o_ss) begin
            sreg <= sreg >> 1;
            sreg[slave_len-1] <= o_mosi;
        end else begin
            sreg <= slave_load & slave_mask;
        end
    end

`ifdef SPI_HOST_LOOPBACK_EN
    assign i_miso = 1'b1;
`else
    assign i_miso = sreg[0];
`endif

    function automatic logic [95:0] mask_of(input int n);
        logic [95:0] m;
        m = '1;
        return n >= 96 ? m : ~(m << n);
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic frame(input string tag, input logic [6:0] len, input logic [95:0] tx,
                         input int slen, input logic [95:0] sload, input logic [95:0] exp_rx_in,
                         input int exp_n, input logic [95:0] exp_slave);
        int ss_n = 0;
        int done_n = 0;
        int mosi_bad = 0;
        logic [95:0] exp_rx = exp_rx_in;
`ifdef SPI_HOST_LOOPBACK_EN
        exp_rx = tx & mask_of(exp_n);
`endif
        slave_len  = slen;
        slave_mask = mask_of(slen);
        slave_load = sload;
        @(negedge clk);
        i_len = len;
        i_tx_data = tx;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (o_ss) begin
                if (ss_n > 95 || o_mosi !== tx[ss_n]) mosi_bad++;
                ss_n++;
            end
            if (o_done) begin
                done_n++;
                check({tag, " slave"}, sreg & slave_mask, exp_slave);
                check({tag, " rx_at_done"}, o_rx_data, exp_rx);
            end
            if (!o_busy) break;
            @(negedge clk);
        end
        check({tag, " ss_cycles"}, 96'(ss_n), 96'(exp_n));
        check({tag, " done_pulses"}, 96'(done_n), 96'd1);
        check({tag, " mosi_errors"}, 96'(mosi_bad), 96'd0);
        check({tag, " rx_idle"}, o_rx_data, exp_rx);
    endtask

    initial begin
        int ss_n;
        int done_n;
        logic ss6, ss7;
        repeat (3) @(negedge clk);
        check("rst ss", 96'(o_ss), 96'd0);
        check("rst mosi", 96'(o_mosi), 96'd0);
        check("rst busy", 96'(o_busy), 96'd0);
        check("rst done", 96'(o_done), 96'd0);
        check("rst rx", o_rx_data, 96'd0);
        rst_n = 1'b1;
        @(negedge clk);

        frame("f96", 7'd96, TX96, 96, A5, A5, 96, TX96);
        frame("f11", 7'd11, 96'h5A3, 11, 96'hBEEF, 96'h6EF, 11, 96'h5A3);
        frame("len0", 7'd0, 96'hFEDCBA98_76543210_13579BDF, 96, 96'h0F0F0F0F_0F0F0F0F_0F0F0F0F,
              96'h0F0F0F0F_0F0F0F0F_0F0F0F0F, 96, 96'hFEDCBA98_76543210_13579BDF);
        frame("len100", 7'd100, 96'h1, 96, 96'hC3C3C3C3_C3C3C3C3_C3C3C3C3,
              96'hC3C3C3C3_C3C3C3C3_C3C3C3C3, 96, 96'h1);
        frame("len1", 7'd1, 96'hFFFF0000_00000000_00000002, 1, 96'h1, 96'h1, 1, 96'h0);

        // abort during ss cycle 40: bits 0..40 have been sampled
        slave_len = 96;
        slave_mask = '1;
        slave_load = A5;
        @(negedge clk);
        i_len = 7'd96;
        i_tx_data = TX96;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (40) @(negedge clk);
        check("abort ss_before", 96'(o_ss), 96'd1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort ss", 96'(o_ss), 96'd0);
        check("abort busy", 96'(o_busy), 96'd0);
`ifdef SPI_HOST_LOOPBACK_EN
        check("abort rx", o_rx_data, TX96 & mask_of(41));
`else
        check("abort rx", o_rx_data, A5 & mask_of(41));
`endif
        done_n = 0;
        for (int i = 0; i < 3; i++) begin
            if (o_done) done_n++;
            @(negedge clk);
        end
        check("abort done", 96'(done_n), 96'd0);
        frame("after_abort", 7'd96, TX96, 96, A5, A5, 96, TX96);

        // reset mid-frame at ss cycle 20
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst ss", 96'(o_ss), 96'd0);
        check("midrst busy", 96'(o_busy), 96'd0);
        check("midrst rx", o_rx_data, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst ss", 96'(o_ss), 96'd0);

        // i_start held high: next frame only after one IDLE cycle
        i_len = 7'd5;
        i_tx_data = 96'h15;
        i_start = 1'b1;
        ss_n = 0;
        done_n = 0;
        ss6 = 1'b0;
        ss7 = 1'b0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (s < 7 && o_ss) ss_n++;
            if (s < 7 && o_done) done_n++;
            if (s == 6) ss6 = o_ss;
            if (s == 7) ss7 = o_ss;
        end
        i_start = 1'b0;
        check("hold ss_cycles", 96'(ss_n), 96'd5);
        check("hold done", 96'(done_n), 96'd1);
        check("hold idle_gap", 96'(ss6), 96'd0);
        check("hold restart", 96'(ss7), 96'd1);
        for (int i = 0; i < 20 && o_busy; i++) @(negedge clk);
        check("hold idle", 96'(o_busy), 96'd0);

`ifdef SPI_HOST_LOOPBACK_EN
        frame("loop", 7'd96, 96'hDEADBEEF, 96, A5, 96'hDEADBEEF, 96, 96'hDEADBEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/spi_host.md
SPI_HOST -- requirements
Module: spi_host

Interface
REQ-001 SHALL have parameter: WIDTH, 96, maximum frame length in bits (1..96).
REQ-002 SHALL have parameter: LEN_W, 7, width of length input, ceil(log2(WIDTH+1)).
REQ-003 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: i_start  input  1  frame request, sampled in IDLE only.
REQ-006 SHALL have port: i_abort  input  1  terminate current frame.
REQ-007 SHALL have port: i_len  input  LEN_W  frame length N; 0 or >WIDTH means WIDTH.
REQ-008 SHALL have port: i_tx_data  input  WIDTH  data to send, bit 0 first.
REQ-009 SHALL have port: o_ss  output  1  active-high select to the shift-register slave.
REQ-010 SHALL have port: o_mosi  output  1  serial data to slave.
REQ-011 SHALL have port: i_miso  input  1  serial data from slave.
REQ-012 SHALL have port: o_rx_data  output  WIDTH  captured frame, bit 0 first received.
REQ-013 SHALL have port: o_busy  output  1  high while not IDLE.
REQ-014 SHALL have port: o_done  output  1  one-cycle frame-complete pulse.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE; all outputs registered.
REQ-016 SHALL in IDLE drive o_ss=0, o_mosi=0, o_busy=0, o_done=0.
REQ-017 SHALL on a rising edge in IDLE with i_start=1 capture i_tx_data and effective N, clear o_rx_data, enter SHIFT.
REQ-018 SHALL in SHIFT hold o_ss=1 for exactly N consecutive cycles; during the k-th ss-high cycle (k=0..N-1) o_mosi=tx[k].
REQ-019 SHALL at each rising edge with o_ss=1 sample i_miso into o_rx_data[k]; bits N..WIDTH-1 remain 0.
REQ-020 SHALL after the N-th ss-high cycle enter DONE: o_ss=0, o_done=1 for exactly one cycle, o_rx_data stable, then IDLE.
REQ-021 SHALL guarantee o_ss low for at least one cycle (IDLE) before every frame so the slave reloads its parallel input.
REQ-022 SHALL ignore i_start in SHIFT and DONE (no queuing); minimum frame-to-frame spacing is N+2 cycles.
REQ-023 SHALL on i_abort=1 in SHIFT go to IDLE next edge: o_ss=0, no o_done, o_rx_data holds partial bits; i_abort has priority over completion on the last bit.
REQ-024 SHALL treat i_abort in IDLE/DONE as no-op; i_start and i_abort together in IDLE starts no frame.
REQ-025 SHALL use a bit counter of LEN_W bits counting 0..N-1 without wrap.

Reset
REQ-026 SHALL on rst_n=0 immediately force IDLE, o_ss=0, o_mosi=0, o_busy=0, o_done=0, o_rx_data=0, including mid-frame.
REQ-027 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL with SPI_HOST_LOOPBACK_EN defined sample o_mosi instead of i_miso (o_rx_data equals sent bits; o_ss/o_mosi still driven).
REQ-029 SHALL without SPI_HOST_LOOPBACK_EN sample i_miso only, with no loopback logic present.

Structure
REQ-030 SHALL place WIDTH/LEN_W defaults and the state enumeration in package spi_host_pkg.
REQ-031 SHALL instantiate one sub-module spi_host_shifter holding tx/rx shift registers and the bit counter; the FSM lives in spi_host.

Verification
REQ-032 SHALL test: i_len=96, tx=96'h0123456789ABCDEF_00FF00FF, slave model returning 96'hA5A5... -> o_ss high exactly 96 cycles, slave holds tx, o_rx_data=96'hA5A5..., o_done one pulse.
REQ-033 SHALL test: i_len=11, tx=11'h5A3 to 11-bit slave returning 16'hBEEF -> 11 ss cycles, slave=11'h5A3, o_rx_data=11'h6EF, upper bits 0.
REQ-034 SHALL test: i_len=0 -> 96-bit frame; i_len=1 -> one ss cycle, o_mosi=tx[0].
REQ-035 SHALL test: i_abort at ss cycle 40 of 96 -> o_ss low next cycle, no o_done, o_busy 0; new i_start then runs a full frame.
REQ-036 SHALL test: rst_n low at ss cycle 20 -> o_ss, o_busy, o_rx_data 0 immediately; i_start held high during SHIFT/DONE -> no second frame until IDLE.
REQ-037 SHALL test with SPI_HOST_LOOPBACK_EN: tx=96'hDEADBEEF, i_miso tied 1 -> o_rx_data=96'hDEADBEEF.
